// File: rtl/mips_fetch_pkg.sv
// Shared types and helpers for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // J/JAL target: keep the region bits of the current PC, splice in instr_index.
  function automatic logic [31:0] jump_addr(input logic [31:0] pc, input logic [25:0] idx);
    return (pc & 32'hF000_0000) | {4'b0000, idx, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux: jump > branch > sequential.
import mips_fetch_pkg::*;

module next_pc_sel (
  input  logic [31:0] pc_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_target_i,
  output logic        redirect_o,
  output logic [31:0] seq_pc_o,
  output logic [31:0] next_pc_o
);

  assign seq_pc_o = pc_i + 32'd4;

  // Pick the highest-priority source; branch targets are forced word-aligned.
  always_comb begin
    redirect_o = jump_i | branch_taken_i;
    next_pc_o  = seq_pc_o;
    if (jump_i) begin
      next_pc_o = jump_addr(pc_i, jump_target_i);
    end else if (branch_taken_i) begin
      next_pc_o = branch_target_i & 32'hFFFF_FFFC;
    end
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Instruction-fetch PC sequencer with imem req/ack handshake and a one-entry
// output slot. Optional macro FETCH_DELAY_SLOT_EN delivers the in-flight
// instruction at a redirect instead of squashing it.
import mips_fetch_pkg::*;

module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               jump,
  input  logic [25:0]        jump_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc_plus4
);

  fetch_state_e       state_q;
  logic               req_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pcp4_q;
  logic               pend_q;
  logic [ADDR_W-1:0]  pend_tgt_q;

  logic               redirect;
  logic [ADDR_W-1:0]  seq_pc;
  logic [ADDR_W-1:0]  next_pc;

  next_pc_sel u_next_pc_sel (
    .pc_i            (addr_q),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .redirect_o      (redirect),
    .seq_pc_o        (seq_pc),
    .next_pc_o       (next_pc)
  );

  // Fetch FSM, fetch address, pending redirect and output slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pcp4_q     <= '0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (stall && valid_q) begin
            // Slot is full and frozen: withdraw the request (an ack here has
            // nowhere to go, so the same address is simply refetched later).
            state_q <= HOLD;
            req_q   <= 1'b0;
            if (redirect) begin
              pend_q     <= 1'b1;
              pend_tgt_q <= next_pc;
            end
          end else if (imem_ack) begin
`ifdef FETCH_DELAY_SLOT_EN
            valid_q <= 1'b1;
            instr_q <= imem_rdata;
            pcp4_q  <= seq_pc;
`else
            if (redirect || pend_q) begin
              valid_q <= 1'b0;
            end else begin
              valid_q <= 1'b1;
              instr_q <= imem_rdata;
              pcp4_q  <= seq_pc;
            end
`endif
            addr_q <= redirect ? next_pc : (pend_q ? pend_tgt_q : seq_pc);
            pend_q <= 1'b0;
          end else begin
            if (!stall) valid_q <= 1'b0;
            if (redirect) begin
              pend_q     <= 1'b1;
              pend_tgt_q <= next_pc;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            // Redirect flushes the stalled slot and overrides the stall.
            valid_q <= 1'b0;
            addr_q  <= next_pc;
            pend_q  <= 1'b0;
            state_q <= REQ;
            req_q   <= 1'b1;
          end else if (!stall) begin
            valid_q <= 1'b0;
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc_plus4 = pcp4_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer.
module tb_fetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;

  int checks = 0;
  int errors = 0;

  fetch_pc_sequencer #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc_plus4   (if_pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] p4);
    chk({tag, "_valid"}, {31'b0, if_valid}, {31'b0, v});
    if (v) begin
      chk({tag, "_instr"}, if_instr, ins);
      chk({tag, "_pcp4"}, if_pc_plus4, p4);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; imem_ack = 1'b0; imem_rdata = '0;
    tick(); tick();
    // Reset state
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pcp4", if_pc_plus4, 32'h0);

    // Release: IDLE -> REQ at RESET_PC
    reset = 1'b0;
    tick();
    chk("rel_req", {31'b0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    chk("rel_valid", {31'b0, if_valid}, 32'd0);

    // Back-to-back acks
    imem_ack = 1'b1; imem_rdata = 32'hA000_0000;
    tick();
    chk_slot("b2b0", 1'b1, 32'hA000_0000, 32'h4);
    chk("b2b0_addr", imem_addr, 32'h4);
    imem_rdata = 32'hA000_0001;
    tick();
    chk_slot("b2b1", 1'b1, 32'hA000_0001, 32'h8);
    chk("b2b1_addr", imem_addr, 32'h8);

    // Ack delayed 3 cycles: address held, slot drains
    imem_ack = 1'b0;
    tick();
    chk("dly_valid", {31'b0, if_valid}, 32'd0);
    chk("dly_addr0", imem_addr, 32'h8);
    tick(); tick();
    chk("dly_addr2", imem_addr, 32'h8);
    chk("dly_req", {31'b0, imem_req}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'hA000_0002;
    tick();
    chk_slot("dly_done", 1'b1, 32'hA000_0002, 32'hC);
    chk("dly_addr_nx", imem_addr, 32'hC);

    // Stall with full slot: frozen, no request, stray acks ignored
    imem_ack = 1'b0; stall = 1'b1;
    tick();
    chk("stl_req0", {31'b0, imem_req}, 32'd0);
    chk_slot("stl0", 1'b1, 32'hA000_0002, 32'hC);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick(); tick(); tick();
    chk("stl_req3", {31'b0, imem_req}, 32'd0);
    chk_slot("stl3", 1'b1, 32'hA000_0002, 32'hC);
    chk("stl_addr", imem_addr, 32'hC);
    imem_ack = 1'b0; stall = 1'b0;
    tick();
    chk("unstl_req", {31'b0, imem_req}, 32'd1);
    chk("unstl_addr", imem_addr, 32'hC);
    chk("unstl_valid", {31'b0, if_valid}, 32'd0);

    // Branch while fetch outstanding (unaligned target bits dropped)
    branch_taken = 1'b1; branch_target = 32'h0000_0101;
    tick();
    chk("br_hold_addr", imem_addr, 32'hC);
    branch_taken = 1'b0; branch_target = '0;
    imem_ack = 1'b1; imem_rdata = 32'hA000_0003;
    tick();
    chk("br_addr", imem_addr, 32'h100);
`ifdef FETCH_DELAY_SLOT_EN
    chk_slot("br_ds", 1'b1, 32'hA000_0003, 32'h10);
`else
    chk_slot("br_sq", 1'b0, 32'h0, 32'h0);
`endif

    // Redirect coinciding with ack
    branch_taken = 1'b1; branch_target = 32'h1000_0010; imem_rdata = 32'hA000_0004;
    tick();
    chk("co_addr", imem_addr, 32'h1000_0010);
`ifdef FETCH_DELAY_SLOT_EN
    chk_slot("co_ds", 1'b1, 32'hA000_0004, 32'h104);
`else
    chk_slot("co_sq", 1'b0, 32'h0, 32'h0);
`endif

    // Jump beats branch
    imem_ack = 1'b0; jump = 1'b1; jump_target = 26'h40;
    branch_taken = 1'b1; branch_target = 32'h0000_0200;
    tick();
    chk("jb_hold_addr", imem_addr, 32'h1000_0010);
    jump = 1'b0; jump_target = '0; branch_taken = 1'b0; branch_target = '0;
    imem_ack = 1'b1; imem_rdata = 32'hA000_0005;
    tick();
    chk("jb_addr", imem_addr, 32'h1000_0100);

    // Redirect in HOLD overrides stall and flushes slot
    imem_rdata = 32'hA000_0006;
    tick();
    chk_slot("hr_fill", 1'b1, 32'hA000_0006, 32'h1000_0104);
    imem_ack = 1'b0; stall = 1'b1;
    tick();
    chk("hr_req0", {31'b0, imem_req}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'h0000_0040;
    tick();
    chk("hr_valid", {31'b0, if_valid}, 32'd0);
    chk("hr_addr", imem_addr, 32'h40);
    chk("hr_req1", {31'b0, imem_req}, 32'd1);
    stall = 1'b0;

    // PC+4 wrap at top of address space
    branch_target = 32'hFFFF_FFFC; imem_ack = 1'b1; imem_rdata = 32'hA000_0007;
    tick();
    chk("wr_addr0", imem_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0; branch_target = '0; imem_rdata = 32'hA000_0008;
    tick();
    chk_slot("wr", 1'b1, 32'hA000_0008, 32'h0);
    chk("wr_addr1", imem_addr, 32'h0);

    // Reset mid-REQ with a coincident ack
    imem_ack = 1'b0; imem_rdata = 32'hA000_0009;
    tick();
    reset = 1'b1; imem_ack = 1'b1;
    tick();
    chk("mr_req", {31'b0, imem_req}, 32'd0);
    chk("mr_addr", imem_addr, 32'h0);
    chk("mr_valid", {31'b0, if_valid}, 32'd0);
    chk("mr_instr", if_instr, 32'h0);
    chk("mr_pcp4", if_pc_plus4, 32'h0);
    reset = 1'b0; imem_ack = 1'b0;
    tick();
    chk("mr_rel_req", {31'b0, imem_req}, 32'd1);
    chk("mr_rel_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hA000_000A;
    tick();
    chk_slot("mr_first", 1'b1, 32'hA000_000A, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
- Instruction-fetch stage of the MIPS datapath.
- Owns the program counter and selects the next PC: sequential, branch or jump.
- Drives a req/ack handshake to instruction memory.
- Presents the fetched instruction and its PC+4 to the downstream 32-bit pipeline register with a valid flag, honouring stall and redirect from decode.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- ADDR_W, 32, PC/address width; only 32 is supported.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high.
- stall  input  1  downstream cannot accept; hold the output slot.
- branch_taken  input  1  decode resolved a taken branch this cycle.
- branch_target  input  32  branch destination; bits [1:0] are ignored and forced to 0.
- jump  input  1  decode holds a J/JAL this cycle.
- jump_target  input  26  instr_index field.
- imem_req  output  1  fetch request.
- imem_addr  output  32  word-aligned fetch address.
- imem_ack  input  1  rdata valid this cycle; may come 1..N cycles after req.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  if_instr/if_pc_plus4 hold a live instruction.
- if_instr  output  32  fetched instruction.
- if_pc_plus4  output  32  address of if_instr + 4.

Behaviour:
- Reset values (any cycle reset=1, including mid-fetch):
  - state=IDLE, imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_instr=0 (NOP), if_pc_plus4=0, redirect_pending=0.
  - A late ack arriving after reset is ignored.
- States:
  - IDLE → REQ on the first cycle with reset=0.
  - REQ: imem_req=1; imem_addr held stable until ack.
  - HOLD: slot full and stall=1; imem_req=0.
- REQ, ack sampled:
  - Instruction is registered into the slot the next cycle: if_valid=1, if_instr=rdata, if_pc_plus4=imem_addr+4. Latency is 1 cycle from ack.
  - If stall=0 at ack, stay in REQ with imem_addr+=4 (back-to-back fetch, one instruction per cycle when ack is immediate).
  - If stall=1 at ack and the slot is full, the ack cannot happen: REQ is only entered while the slot is free or being drained.
- Stall:
  - While stall=1 and if_valid=1, the slot holds and no new req is issued (REQ→HOLD once the current ack completes).
  - HOLD→REQ in the cycle after stall falls.
  - Slot drains (if_valid→0) when stall=0 and no new instruction arrives.
- Redirect (branch_taken or jump):
  - Priority: jump > branch_taken > sequential.
  - Jump address = {imem_addr[31:28], jump_target, 2'b00}.
  - The request in flight is not abandoned: addr stays stable until ack. Its returned instruction is squashed (not written, if_valid=0 next cycle), and the next req uses the target.
  - If redirect and ack coincide, the ack data is squashed and the target is issued the following cycle.
  - Redirect while in HOLD: the slot is flushed (if_valid=0) and REQ to the target starts the next cycle, overriding stall.
  - redirect_pending captures the target when no ack is present, and is cleared when the target req is issued.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

Optional Feature:
- FETCH_DELAY_SLOT_EN defined: the instruction in flight at redirect (the delay slot) is delivered with if_valid=1, and the target is fetched after it.
- Undefined: the in-flight instruction is squashed as described above.

Decomposition:
- Shared package mips_fetch_pkg:
  - state enum {IDLE, REQ, HOLD}
  - NOP_INSTR=32'h0
  - INSTR_W=32
  - function jump_addr(pc, idx)
- Sub-module next_pc_sel (combinational priority mux for seq/branch/jump) is natural; the rest stays in the top.

Test Plan:
- Reset release with ack every cycle → imem_addr 0,4,8,…; if_pc_plus4 4,8,12 one cycle after each ack; if_valid continuous.
- Ack delayed 3 cycles → imem_addr held at 0x4 for 3 cycles, if_valid=0 during the wait, instr delivered 1 cycle after ack.
- stall=1 for 4 cycles with slot full → if_instr/if_pc_plus4 frozen, imem_req=0. Release → next addr = held PC+4.
- branch_taken with target 0x100 while fetch 0x8 is outstanding:
  - Without macro: 0x8 data squashed, next imem_addr=0x100.
  - With FETCH_DELAY_SLOT_EN: 0x8 delivered valid, then 0x100.
- jump + branch_taken together, jump_target=26'h40, imem_addr=0x1000_0010 → next addr 0x1000_0100; branch ignored.
- reset asserted mid-REQ with ack arriving the same cycle → all outputs return to reset values next cycle; first post-reset req at RESET_PC.
